// File: rtl/capture_sequencer_if.sv
// Sample-stream and transmit-stream signals between the signal reader,
// the capture sequencer and the USB transmitter.
interface capture_sequencer_if #(
  parameter int SAMPLE_W = 12
);
  logic                  sample_valid;
  logic [2*SAMPLE_W-1:0] sample_data;
  logic [2*SAMPLE_W-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  // Environment side: sample source plus transmitter.
  modport master (output sample_valid, sample_data, tx_ready, input tx_data, tx_valid);
  // Sequencer side.
  modport slave  (input sample_valid, sample_data, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/capture_sequencer.sv
// Oscilloscope acquisition sequencer: arm, decimate, level trigger, fill buffer, drain.
// Optional FORCE_TRIGGER_EN adds force_trig to trigger on the next kept sample.
module capture_sequencer #(
  parameter int SAMPLE_W = 12,
  parameter int DEPTH    = 256,
  parameter int DECIM_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_rising,
  input  logic                trig_chan,
  input  logic [DECIM_W-1:0]  decim,
`ifdef FORCE_TRIGGER_EN
  input  logic                force_trig,
`endif
  capture_sequencer_if.slave  bus,
  output logic [1:0]          state,
  output logic                busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = 2 * SAMPLE_W;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DECIM_W-1:0]  decim_q, decim_d;
  logic [DECIM_W-1:0]  dcnt_q, dcnt_d;
  logic [SAMPLE_W-1:0] prev_q, prev_d;
  logic                prev_vld_q, prev_vld_d;
  logic                force_pend_q, force_pend_d;
  logic [CW-1:0]       wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                rd_pend_q, rd_pend_d;
  logic                tx_valid_q, tx_valid_d;
  logic [DW-1:0]       tx_data_q, tx_data_d;

  logic [DW-1:0]       mem_q [DEPTH];
  logic [DW-1:0]       ram_rd_q;
  logic                wr_en, rd_en;

  logic                kept, level_hit, trig_hit, force_now;
  logic [SAMPLE_W-1:0] cur;

`ifdef FORCE_TRIGGER_EN
  assign force_now = force_trig;
`else
  assign force_now = 1'b0;
`endif

  assign kept = bus.sample_valid && (dcnt_q == decim_q);
  assign cur  = trig_chan ? bus.sample_data[DW-1:SAMPLE_W] : bus.sample_data[SAMPLE_W-1:0];

  always_comb begin
    if (trig_rising) level_hit = (prev_q < trig_level) && (cur >= trig_level);
    else             level_hit = (prev_q > trig_level) && (cur <= trig_level);
  end

  assign trig_hit = (prev_vld_q && level_hit) || force_pend_q || force_now;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    decim_d      = decim_q;
    dcnt_d       = dcnt_q;
    prev_d       = prev_q;
    prev_vld_d   = prev_vld_q;
    force_pend_d = force_pend_q;
    wr_cnt_d     = wr_cnt_q;
    rd_ptr_d     = rd_ptr_q;
    rd_pend_d    = 1'b0;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    wr_en        = 1'b0;
    rd_en        = 1'b0;

    case (state_q)
      IDLE: if (enable) state_d = ARMED;
      ARMED: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          force_pend_d = force_pend_q | force_now;
          if (bus.sample_valid) dcnt_d = kept ? '0 : dcnt_q + DECIM_W'(1);
          if (kept) begin
            prev_d     = cur;
            prev_vld_d = 1'b1;
            if (trig_hit) begin
              wr_en    = 1'b1;
              wr_cnt_d = CW'(1);
              state_d  = CAPTURE;
            end
          end
        end
      end
      CAPTURE: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          if (bus.sample_valid) dcnt_d = kept ? '0 : dcnt_q + DECIM_W'(1);
          if (kept) begin
            wr_en    = 1'b1;
            wr_cnt_d = wr_cnt_q + CW'(1);
            if (wr_cnt_q == CNT_LAST) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // One read in flight at most; tx_data is loaded the cycle after the RAM read.
        if (rd_pend_q) begin
          tx_data_d  = ram_rd_q;
          tx_valid_d = 1'b1;
        end
        if (tx_valid_q && bus.tx_ready) begin
          tx_valid_d = 1'b0;
          if (rd_ptr_q == CNT_FULL) state_d = enable ? ARMED : IDLE;
        end
        if (!rd_pend_q && (!tx_valid_q || bus.tx_ready) && rd_ptr_q != CNT_FULL) begin
          rd_en     = 1'b1;
          rd_ptr_d  = rd_ptr_q + CW'(1);
          rd_pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any return to IDLE or ARMED starts the next acquisition from scratch.
    if (state_d != state_q && (state_d == IDLE || state_d == ARMED)) begin
      wr_cnt_d   = '0;
      rd_ptr_d   = '0;
      prev_vld_d = 1'b0;
      dcnt_d     = '0;
      if (state_d == ARMED) decim_d = decim;
    end
    if (state_d != ARMED) force_pend_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      decim_q      <= '0;
      dcnt_q       <= '0;
      prev_q       <= '0;
      prev_vld_q   <= 1'b0;
      force_pend_q <= 1'b0;
      wr_cnt_q     <= '0;
      rd_ptr_q     <= '0;
      rd_pend_q    <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      decim_q      <= decim_d;
      dcnt_q       <= dcnt_d;
      prev_q       <= prev_d;
      prev_vld_q   <= prev_vld_d;
      force_pend_q <= force_pend_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_pend_q    <= rd_pend_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
    end
  end

  // NOTE: the buffer has no reset so it maps to block RAM; entries are always written before read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_cnt_q[AW-1:0]] <= bus.sample_data;
    if (rd_en) ram_rd_q <= mem_q[rd_ptr_q[AW-1:0]];
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign state        = state_q;
  assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer: vector table plus directed multi-cycle sequences.
module tb_capture_sequencer;
  localparam int SW    = 12;
  localparam int DEPTH = 8;
  localparam int DCW   = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           enable = 1'b0;
  logic [SW-1:0]  trig_level = 12'h800;
  logic           trig_rising = 1'b1;
  logic           trig_chan = 1'b0;
  logic [DCW-1:0] decim = '0;
`ifdef FORCE_TRIGGER_EN
  logic           force_trig = 1'b0;
`endif
  logic [1:0]     state;
  logic           busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] exp_buf [DEPTH];

  capture_sequencer_if #(.SAMPLE_W(SW)) bus ();

  capture_sequencer #(.SAMPLE_W(SW), .DEPTH(DEPTH), .DECIM_W(DCW)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .trig_level  (trig_level),
    .trig_rising (trig_rising),
    .trig_chan   (trig_chan),
    .decim       (decim),
`ifdef FORCE_TRIGGER_EN
    .force_trig  (force_trig),
`endif
    .bus         (bus),
    .state       (state),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        en;
    logic        sv;
    logic [23:0] d;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs [25];

  function automatic vec_t mk(input logic en, input logic sv, input logic [23:0] d, input logic [1:0] st);
    vec_t v;
    v.en = en; v.sv = sv; v.d = d; v.st = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Consumes DEPTH entries, checking order, hold-under-backpressure and presentation latency.
  task automatic drain(input bit rnd, input logic [1:0] st_after, input string tag);
    int          idx = 0;
    int          first = -1;
    int          last_hs = -1;
    bit          held = 1'b0;
    logic [23:0] held_d = '0;
    logic        rdy;
    for (int cyc = 0; cyc < 200 && idx < DEPTH; cyc++) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.tx_ready = rdy;
      if (held) begin
        check($sformatf("%s_hold_valid", tag), 32'(bus.tx_valid), 32'd1);
        check($sformatf("%s_hold_data", tag), 32'(bus.tx_data), 32'(held_d));
      end else if (bus.tx_valid) begin
        if (first < 0) begin
          first = cyc;
          check($sformatf("%s_first_latency_le2", tag), 32'(first <= 2), 32'd1);
        end else begin
          check($sformatf("%s_gap_le2", tag), 32'(cyc - last_hs <= 2), 32'd1);
        end
      end
      if (bus.tx_valid && rdy) begin
        check($sformatf("%s_data%0d", tag, idx), 32'(bus.tx_data), 32'(exp_buf[idx]));
        idx++;
        last_hs = cyc;
      end
      held   = bus.tx_valid && !rdy;
      held_d = bus.tx_data;
      step();
    end
    check($sformatf("%s_handshakes", tag), 32'(idx), 32'(DEPTH));
    check($sformatf("%s_valid_drop", tag), 32'(bus.tx_valid), 32'd0);
    check($sformatf("%s_state_after", tag), 32'(state), 32'(st_after));
    bus.tx_ready = 1'b0;
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    bus.tx_ready     = 1'b0;

    // Rising ch0 level 0x800, decim 0: abort paths, then a full capture.
    vecs[0]  = mk(1'b0, 1'b1, 24'h000800, 2'd0);
    vecs[1]  = mk(1'b1, 1'b0, 24'h000000, 2'd1);
    vecs[2]  = mk(1'b1, 1'b1, 24'h0007F0, 2'd1);
    vecs[3]  = mk(1'b0, 1'b1, 24'h000800, 2'd0);
    vecs[4]  = mk(1'b1, 1'b0, 24'h000000, 2'd1);
    vecs[5]  = mk(1'b1, 1'b1, 24'h000800, 2'd1);
    vecs[6]  = mk(1'b1, 1'b1, 24'h0007FF, 2'd1);
    vecs[7]  = mk(1'b1, 1'b1, 24'h000800, 2'd2);
    vecs[8]  = mk(1'b1, 1'b1, 24'h000801, 2'd2);
    vecs[9]  = mk(1'b1, 1'b1, 24'h000802, 2'd2);
    vecs[10] = mk(1'b0, 1'b1, 24'h000803, 2'd0);
    vecs[11] = mk(1'b0, 1'b0, 24'h000000, 2'd0);
    vecs[12] = mk(1'b0, 1'b0, 24'h000000, 2'd0);
    vecs[13] = mk(1'b1, 1'b0, 24'h000000, 2'd1);
    vecs[14] = mk(1'b1, 1'b1, 24'h0007F0, 2'd1);
    vecs[15] = mk(1'b1, 1'b1, 24'h0007F8, 2'd1);
    vecs[16] = mk(1'b1, 1'b1, 24'h000800, 2'd2);
    vecs[17] = mk(1'b1, 1'b0, 24'h000000, 2'd2);
    vecs[18] = mk(1'b1, 1'b1, 24'h000808, 2'd2);
    vecs[19] = mk(1'b1, 1'b1, 24'h000810, 2'd2);
    vecs[20] = mk(1'b1, 1'b1, 24'h000818, 2'd2);
    vecs[21] = mk(1'b1, 1'b1, 24'h000820, 2'd2);
    vecs[22] = mk(1'b1, 1'b1, 24'h000828, 2'd2);
    vecs[23] = mk(1'b1, 1'b1, 24'h000830, 2'd2);
    vecs[24] = mk(1'b1, 1'b1, 24'h000838, 2'd3);

    // Reset state
    step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // tx_ready held high in the table: no effect while tx_valid is low
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      enable           = vecs[i].en;
      bus.sample_valid = vecs[i].sv;
      bus.sample_data  = vecs[i].d;
      step();
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].st != 2'd0));
      check($sformatf("vec%0d_tx_valid", i), 32'(bus.tx_valid), 32'd0);
    end
    bus.sample_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) exp_buf[k] = 24'(24'h000800 + 8 * k);
    drain(1'b0, 2'd1, "rise");

    // Falling trigger on ch1 with decim 2: kept samples are i = 2, 5, 8, ...; trigger at i = 5 (0x400).
    enable = 1'b0;
    step();
    check("fall_idle", 32'(state), 32'd0);
    trig_rising = 1'b0;
    trig_chan   = 1'b1;
    trig_level  = 12'h400;
    decim       = 8'd2;
    enable      = 1'b1;
    step();
    check("fall_armed", 32'(state), 32'd1);
    for (int i = 0; i <= 26; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_data  = {12'(12'h450 - 16 * i), 12'(i)};
      step();
      check($sformatf("fall_s%0d_state", i), 32'(state), (i < 5) ? 32'd1 : (i < 26) ? 32'd2 : 32'd3);
    end
    bus.sample_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) exp_buf[k] = {12'(12'h450 - 16 * (5 + 3 * k)), 12'(5 + 3 * k)};
    drain(1'b1, 2'd1, "fall_bp");

    // Same acquisition again, enable dropped once draining: all entries still delivered, then IDLE.
    for (int i = 0; i <= 26; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_data  = {12'(12'h450 - 16 * i), 12'(i)};
      step();
    end
    bus.sample_valid = 1'b0;
    check("endrain_in_drain", 32'(state), 32'd3);
    enable = 1'b0;
    drain(1'b1, 2'd0, "endrain");
    step();
    check("endrain_stays_idle", 32'(state), 32'd0);

    // Constant above level never produces a rising crossing.
    trig_rising = 1'b1;
    trig_chan   = 1'b0;
    trig_level  = 12'h800;
    decim       = 8'd0;
    enable      = 1'b1;
    step();
    for (int i = 0; i < 40; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_data  = {12'(i), 12'h900};
      step();
    end
    bus.sample_valid = 1'b0;
    check("nofalse_state", 32'(state), 32'd1);
    check("nofalse_busy", 32'(busy), 32'd1);
`ifdef FORCE_TRIGGER_EN
    force_trig = 1'b1;
    step();
    force_trig = 1'b0;
    check("force_still_armed", 32'(state), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_data  = {12'(12'h100 + i), 12'h900};
      exp_buf[i]       = {12'(12'h100 + i), 12'h900};
      step();
      check($sformatf("force_s%0d_state", i), 32'(state), (i < DEPTH - 1) ? 32'd2 : 32'd3);
    end
    bus.sample_valid = 1'b0;
    drain(1'b0, 2'd1, "force");
`endif

    // Asynchronous reset in the middle of a capture.
    bus.sample_valid = 1'b1;
    bus.sample_data  = 24'h0007F0;
    step();
    bus.sample_data  = 24'h000800;
    step();
    bus.sample_data  = 24'h000810;
    step();
    bus.sample_valid = 1'b0;
    check("rstmid_capture", 32'(state), 32'd2);
    reset = 1'b0;
    #1;
    check("rstmid_state", 32'(state), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_tx_valid", 32'(bus.tx_valid), 32'd0);
    step();
    reset = 1'b1;
    step();
    check("rstmid_rearm", 32'(state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
